// File: rtl/counter_sequencer.sv
// Command-driven sequencer for a WIDTH-bit up-counter: accepts a terminal count over
// valid/ready, then counts 0..limit in one-shot or auto-reload mode, with pause and abort.
module counter_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic             cmd_reload,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] Count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] limit_q;
    logic             reload_q;
    logic             done_next;
    logic             accept;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Count    <= '0;
            done     <= 1'b0;
            limit_q  <= '0;
            reload_q <= 1'b0;
        end else begin
            Count <= count_next;
            done  <= done_next;
            if (accept) begin
                limit_q  <= cmd_limit;
                reload_q <= cmd_reload;
            end
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        count_next = Count;
        done_next  = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept     = 1'b1;
                    count_next = '0;
                    if (cmd_limit != '0) begin
                        state_next = S_RUN;
                    end else begin
                        // A zero limit hits terminal count immediately; in reload mode
                        // it keeps doing so, giving a done pulse every cycle.
                        done_next  = 1'b1;
                        state_next = cmd_reload ? S_RUN : S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_next = S_IDLE;
                    count_next = '0;
                end else if (pause) begin
                    state_next = S_HOLD;
                end else if (Count == limit_q) begin
                    done_next = 1'b1;
                    if (reload_q) begin
                        count_next = '0;
                    end else begin
                        state_next = S_DONE;
                    end
                end else begin
                    count_next = Count + 1'b1;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    state_next = S_IDLE;
                    count_next = '0;
                end else if (!pause) begin
                    state_next = S_RUN;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                if (abort) begin
                    count_next = '0;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        cmd_ready = (state == S_IDLE) && !abort;
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: directed scenarios followed by random
// stimulus, all compared cycle by cycle against a flag-based behavioural model.
module tb_counter_sequencer;

    localparam int WIDTH = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_limit = '0;
    logic             cmd_reload = 1'b0;
    logic             pause = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] Count;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;
    int t        = 0;

    // Model: a sequence is either counting, held by pause, or in its final cycle.
    bit m_run, m_hold, m_fin, m_reload, m_done;
    int m_count, m_limit;

    counter_sequencer #(.WIDTH(WIDTH)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_limit  (cmd_limit),
        .cmd_reload (cmd_reload),
        .pause      (pause),
        .abort      (abort),
        .Count      (Count),
        .busy       (busy),
        .done       (done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_idle();
        return !(m_run || m_hold || m_fin);
    endfunction

    task automatic model_step();
        bit idle;
        idle = m_idle();
        if (RST) begin
            m_run = 0; m_hold = 0; m_fin = 0; m_reload = 0; m_done = 0;
            m_count = 0; m_limit = 0;
        end else begin
            m_done = 0;
            if (idle) begin
                if (cmd_valid && !abort) begin
                    m_limit  = int'(cmd_limit);
                    m_reload = cmd_reload;
                    m_count  = 0;
                    if (m_limit == 0) begin
                        m_done = 1;
                        if (m_reload) m_run = 1;
                        else          m_fin = 1;
                    end else begin
                        m_run = 1;
                    end
                end
            end else if (m_fin) begin
                m_fin = 0;
                if (abort) m_count = 0;
            end else if (abort) begin
                m_run = 0; m_hold = 0; m_count = 0;
            end else if (m_hold) begin
                if (!pause) begin
                    m_hold = 0; m_run = 1;
                end
            end else begin
                if (pause) begin
                    m_run = 0; m_hold = 1;
                end else if (m_count == m_limit) begin
                    m_done = 1;
                    if (m_reload) m_count = 0;
                    else begin
                        m_run = 0; m_fin = 1;
                    end
                end else begin
                    m_count = m_count + 1;
                end
            end
        end
    endtask

    // One clock edge: advance the model with the current inputs, then compare.
    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        t++;
        check("count", 32'(Count), 32'(m_count));
        check("busy", 32'(busy), 32'(!m_idle()));
        check("done", 32'(done), 32'(m_done));
        check("ready", 32'(cmd_ready), 32'(m_idle() && !abort));
    endtask

    task automatic issue(input int lim, input bit rel);
        cmd_valid  = 1'b1;
        cmd_limit  = WIDTH'(lim);
        cmd_reload = rel;
        tick();
        cmd_valid = 1'b0;
        t = 0;
    endtask

    task automatic watch(input int n, output int first, output int pulses);
        first  = -1;
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done === 1'b1) begin
                pulses++;
                if (first < 0) first = t;
            end
        end
    endtask

    initial begin
        int first, pulses, max_seen;

        // Reset
        RST = 1'b1;
        repeat (2) tick();
        RST = 1'b0;
        check("reset_count", 32'(Count), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_ready", 32'(cmd_ready), 1);

        // One-shot, limit 5
        issue(5, 0);
        watch(8, first, pulses);
        check("oneshot_done_at", first, 6);
        check("oneshot_pulses", pulses, 1);
        check("oneshot_hold_limit", 32'(Count), 5);
        check("oneshot_ready", 32'(cmd_ready), 1);

        // Auto-reload, limit 3
        issue(3, 1);
        watch(12, first, pulses);
        check("reload_first", first, 4);
        check("reload_pulses", pulses, 3);
        check("reload_busy", 32'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("reload_abort_busy", 32'(busy), 0);

        // Pause for 3 cycles at Count=2, limit 7
        issue(7, 0);
        repeat (2) tick();
        check("pause_pre", 32'(Count), 2);
        pause = 1'b1;
        repeat (3) tick();
        pause = 1'b0;
        watch(10, first, pulses);
        check("pause_done_at", first, 12);
        check("pause_pulses", pulses, 1);

        // Abort in IDLE masks cmd_ready
        abort = 1'b1;
        cmd_valid = 1'b1;
        cmd_limit = 4;
        tick();
        check("idle_abort_ready", 32'(cmd_ready), 0);
        check("idle_abort_busy", 32'(busy), 0);
        abort = 1'b0;
        cmd_valid = 1'b0;

        // Command blocked while busy, then accepted after abort
        issue(9, 0);
        repeat (4) tick();
        cmd_valid = 1'b1;
        cmd_limit = 2;
        cmd_reload = 1'b0;
        repeat (2) tick();
        check("blocked_count", 32'(Count), 6);
        abort = 1'b1;
        tick();
        check("abort_count", 32'(Count), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        abort = 1'b0;
        tick();
        t = 0;
        check("pending_accepted", 32'(busy), 1);
        cmd_valid = 1'b0;
        watch(5, first, pulses);
        check("pending_done_at", first, 3);

        // limit 0 one-shot
        issue(0, 0);
        check("zero_done", 32'(done), 1);
        check("zero_count", 32'(Count), 0);
        tick();
        check("zero_idle", 32'(busy), 0);

        // limit 15, no wrap
        issue(15, 0);
        max_seen = 0;
        first = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (int'(Count) > max_seen) max_seen = int'(Count);
            if (done === 1'b1 && first < 0) first = t;
        end
        check("max_done_at", first, 16);
        check("max_count", max_seen, 15);

        // Pause asserted when Count == limit
        issue(3, 0);
        repeat (3) tick();
        pause = 1'b1;
        repeat (2) tick();
        pause = 1'b0;
        watch(4, first, pulses);
        check("pause_at_limit_done", first, 7);

        // Reset mid-run
        issue(10, 0);
        repeat (6) tick();
        check("midrun_count", 32'(Count), 6);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("midrun_rst_count", 32'(Count), 0);
        check("midrun_rst_busy", 32'(busy), 0);
        check("midrun_rst_done", 32'(done), 0);
        check("midrun_rst_ready", 32'(cmd_ready), 1);

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            RST        = ($urandom_range(0, 299) == 0);
            cmd_valid  = $urandom_range(0, 1) == 1;
            cmd_limit  = WIDTH'($urandom);
            cmd_reload = $urandom_range(0, 1) == 1;
            pause      = ($urandom_range(0, 4) == 0);
            abort      = ($urandom_range(0, 24) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
